// File: rtl/proc_run_ctrl.sv
// Run controller between top-level clock/reset and the processor core: stretched core reset,
// registered clock-enable, bounded/free/step runs and a saturating cycle counter.
// Optional synchronous soft reset of the core via macro PROC_RUN_SOFT_RESET_EN.
module proc_run_ctrl #(
   parameter int CYCLE_W         = 32,
   parameter int RST_HOLD_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [CYCLE_W-1:0] run_len,
   input  logic               step,
   input  logic               stop,
   input  logic               clr_count,
`ifdef PROC_RUN_SOFT_RESET_EN
   input  logic               soft_reset_req,
`endif
   output logic               core_reset,
   output logic               core_ce,
   output logic [CYCLE_W-1:0] cycle_count,
   output logic               running,
   output logic               done
);

   typedef enum logic [2:0] {
      S_HOLD = 3'd0,
      S_IDLE = 3'd1,
      S_RUN  = 3'd2,
      S_STEP = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [7:0]         HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);
   localparam logic [CYCLE_W-1:0] CNT_ONE   = CYCLE_W'(1);
   localparam logic [CYCLE_W-1:0] CNT_ZERO  = CYCLE_W'(0);
   localparam logic [CYCLE_W-1:0] CNT_MAX   = {CYCLE_W{1'b1}};

   state_t             state_r;
   logic [7:0]         hold_cnt_r;
   logic [CYCLE_W-1:0] remaining_r;
   logic               soft_rst_s;

   function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + CNT_ONE;
      end
   endfunction

`ifdef PROC_RUN_SOFT_RESET_EN
   assign soft_rst_s = soft_reset_req;
`else
   assign soft_rst_s = 1'b0;
`endif

   // Run-control state machine with all outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= S_HOLD;
         hold_cnt_r  <= 8'd0;
         remaining_r <= CNT_ZERO;
         core_reset  <= 1'b1;
         core_ce     <= 1'b0;
         cycle_count <= CNT_ZERO;
         running     <= 1'b0;
         done        <= 1'b0;
      end else if (soft_rst_s && (state_r != S_HOLD)) begin
         // Counter deliberately kept so software can read how far the core got.
         state_r    <= S_HOLD;
         hold_cnt_r <= 8'd0;
         core_reset <= 1'b1;
         core_ce    <= 1'b0;
         running    <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state_r)
            S_HOLD: begin
               hold_cnt_r <= hold_cnt_r + 8'd1;
               if (hold_cnt_r == HOLD_LAST) begin
                  state_r    <= S_IDLE;
                  core_reset <= 1'b0;
               end else begin
                  core_reset <= 1'b1;
               end
            end
            S_IDLE, S_DONE: begin
               if (start) begin
                  remaining_r <= run_len;
                  state_r     <= S_RUN;
                  core_ce     <= 1'b1;
                  running     <= 1'b1;
                  done        <= 1'b0;
               end else if (step) begin
                  state_r <= S_STEP;
                  core_ce <= 1'b1;
                  running <= 1'b1;
                  done    <= 1'b0;
               end else if (clr_count) begin
                  cycle_count <= CNT_ZERO;
               end else begin
                  state_r <= state_r;
               end
            end
            S_RUN: begin
               cycle_count <= sat_inc(cycle_count);
               if (remaining_r != CNT_ZERO) begin
                  remaining_r <= remaining_r - CNT_ONE;
               end else begin
                  remaining_r <= CNT_ZERO;
               end
               // Stop wins over completion of the final bounded cycle.
               if (stop) begin
                  state_r <= S_IDLE;
                  core_ce <= 1'b0;
                  running <= 1'b0;
                  done    <= 1'b0;
               end else if (remaining_r == CNT_ONE) begin
                  state_r <= S_DONE;
                  core_ce <= 1'b0;
                  running <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  state_r <= S_RUN;
               end
            end
            S_STEP: begin
               cycle_count <= sat_inc(cycle_count);
               state_r     <= S_IDLE;
               core_ce     <= 1'b0;
               running     <= 1'b0;
            end
            default: begin
               state_r     <= S_HOLD;
               hold_cnt_r  <= 8'd0;
               remaining_r <= CNT_ZERO;
               core_reset  <= 1'b1;
               core_ce     <= 1'b0;
               running     <= 1'b0;
               done        <= 1'b0;
            end
         endcase
      end
   end

endmodule
